// File: rtl/i2c_tx_pingpong_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_tx_pingpong_master : double-buffered I2C write master with SCL timing  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module i2c_tx_pingpong_master #(
  parameter int BUF_BYTES = 2,
  parameter int CLK_DIV   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   StartTX,
  input  logic [6:0]             SlaveAddr,
  input  logic [CNT_W-1:0]       NumBytes,
  input  logic [8*BUF_BYTES-1:0] WrData,
  input  logic                   WrValid,
  output logic                   WrReady,
  input  logic                   SDA_i,
  output logic                   SDA_oe,
  output logic                   SCL_oe,
  output logic                   Busy,
  output logic                   Done,
  output logic                   NackErr
);

  localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  logic [2:0]             state, next_state;
  logic [QW-1:0]          qcnt;
  logic [1:0]             quarter;
  logic [2:0]             bit_cnt;
  logic [6:0]             addr;
  logic [CNT_W-1:0]       num_bytes, bytes_loaded, bytes_sent;
  logic [8*BUF_BYTES-1:0] bufs [2];
  logic [1:0]             buf_full;
  logic                   load_sel, rd_sel;
  logic [BW-1:0]          byte_idx;
  logic                   ack_nack, nack_err, done;

  logic             q_end, bit_end, counting, byte_last, load;
  logic [7:0]       addr_byte, cur_byte;
  logic [CNT_W-1:0] remaining, load_inc;

  assign counting  = (state == S_START) || (state == S_ADDR) || (state == S_DATA) ||
                     (state == S_ACK) || (state == S_STOP);
  assign q_end     = (qcnt == QW'(CLK_DIV - 1));
  assign bit_end   = q_end && (quarter == 2'd3);
  assign addr_byte = {addr, 1'b0};
  assign remaining = num_bytes - bytes_loaded;
  assign load_inc  = (remaining >= CNT_W'(BUF_BYTES)) ? CNT_W'(BUF_BYTES) : remaining;
  assign byte_last = (byte_idx == BW'(BUF_BYTES - 1)) || ((bytes_sent + 1'b1) == num_bytes);
  assign Busy      = (state != S_IDLE);
  assign WrReady   = Busy && !buf_full[load_sel] && (bytes_loaded < num_bytes);
  assign load      = WrReady && WrValid;
  assign Done      = done;
  assign NackErr   = nack_err;

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < BUF_BYTES; i++) begin
      if (byte_idx == BW'(i)) cur_byte = bufs[rd_sel][8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (StartTX) next_state = S_START;
      S_START: if (bit_end) next_state = S_ADDR;
      S_ADDR,
      S_DATA:  if (bit_end && bit_cnt == 3'd7) next_state = S_ACK;
      S_ACK: begin
        if (bit_end) begin
          if (ack_nack)                    next_state = S_STOP;
          else if (bytes_sent < num_bytes) next_state = buf_full[rd_sel] ? S_DATA : S_WAIT;
          else                             next_state = S_STOP;
        end
      end
      S_WAIT:  if (buf_full[rd_sel]) next_state = S_DATA;
      S_STOP:  if (bit_end) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    SDA_oe = 1'b0;
    SCL_oe = 1'b0;
    case (state)
      S_START: SDA_oe = quarter[1];
      S_ADDR: begin
        SCL_oe = !quarter[1];
        SDA_oe = !addr_byte[3'd7 - bit_cnt];
      end
      S_DATA: begin
        SCL_oe = !quarter[1];
        SDA_oe = !cur_byte[3'd7 - bit_cnt];
      end
      S_ACK:   SCL_oe = !quarter[1];
      S_WAIT:  SCL_oe = 1'b1;
      S_STOP: begin
        SCL_oe = !quarter[1];
        SDA_oe = (quarter != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0; quarter <= 2'd0; bit_cnt <= 3'd0; addr <= 7'd0;
      num_bytes <= '0; bytes_loaded <= '0; bytes_sent <= '0;
      bufs[0] <= '0; bufs[1] <= '0; buf_full <= 2'b00;
      load_sel <= 1'b0; rd_sel <= 1'b0; byte_idx <= '0;
      ack_nack <= 1'b0; nack_err <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (counting) begin
        if (q_end) begin
          qcnt    <= '0;
          quarter <= quarter + 2'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end else begin
        qcnt    <= '0;
        quarter <= 2'd0;
      end
      if (next_state != state)                                bit_cnt <= 3'd0;
      else if (bit_end && (state == S_ADDR || state == S_DATA)) bit_cnt <= bit_cnt + 3'd1;
      if (state == S_IDLE && StartTX) begin
        addr      <= SlaveAddr;
        num_bytes <= NumBytes;
        nack_err  <= 1'b0;
      end
      if (state == S_ACK && quarter == 2'd2 && q_end) ack_nack <= SDA_i;
      if (state == S_ACK && bit_end && ack_nack)      nack_err <= 1'b1;
      if (load) begin
        bufs[load_sel]     <= WrData;
        buf_full[load_sel] <= 1'b1;
        load_sel           <= !load_sel;
        bytes_loaded       <= bytes_loaded + load_inc;
      end
      if (state == S_DATA && bit_end && bit_cnt == 3'd7) begin
        bytes_sent <= bytes_sent + 1'b1;
        if (byte_last) begin
          buf_full[rd_sel] <= 1'b0;
          rd_sel           <= !rd_sel;
          byte_idx         <= '0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
      // Leaving STOP discards anything still buffered, including after a NACK.
      if (state == S_STOP && bit_end) begin
        done         <= 1'b1;
        buf_full     <= 2'b00;
        load_sel     <= 1'b0;
        rd_sel       <= 1'b0;
        byte_idx     <= '0;
        bytes_loaded <= '0;
        bytes_sent   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_pingpong_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_tx_pingpong_master : directed bench with a bus monitor/slave model |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_i2c_tx_pingpong_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StartTX = 1'b0;
  logic [6:0]  SlaveAddr = 7'd0;
  logic [15:0] NumBytes = 16'd0;
  logic [15:0] WrData = 16'd0;
  logic        WrValid = 1'b0;
  logic        WrReady;
  logic        SDA_i;
  logic        SDA_oe, SCL_oe, Busy, Done, NackErr;

  int checks = 0;
  int errors = 0;

  i2c_tx_pingpong_master #(.BUF_BYTES(2), .CLK_DIV(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .StartTX(StartTX), .SlaveAddr(SlaveAddr),
    .NumBytes(NumBytes), .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .SDA_i(SDA_i), .SDA_oe(SDA_oe), .SCL_oe(SCL_oe), .Busy(Busy), .Done(Done),
    .NackErr(NackErr)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: collects bytes on SCL rising edges, ACKs on the 9th bit.
  logic       slave_pull = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] sh = 8'd0;
  logic [7:0] cap [$];
  int mcyc = 0, bitn = 0, byte_no = 0, starts = 0, stops = 0;
  int last_rise = -1, min_per = 0, max_per = 0;
  int nack_byte = -1;
  logic scl_line, sda_line;
  assign scl_line = ~SCL_oe;
  assign sda_line = ~(SDA_oe | slave_pull);
  assign SDA_i    = sda_line;

  always @(negedge clk) begin
    logic [7:0] t;
    mcyc = mcyc + 1;
    if (scl_line && prev_scl && prev_sda && !sda_line) begin
      starts = starts + 1; bitn = 0; byte_no = 0;
      last_rise = -1; min_per = 1000000; max_per = 0;
    end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
      stops = stops + 1;
    end
    if (scl_line && !prev_scl) begin
      if (last_rise >= 0) begin
        if (mcyc - last_rise < min_per) min_per = mcyc - last_rise;
        if (mcyc - last_rise > max_per) max_per = mcyc - last_rise;
      end
      last_rise = mcyc;
      if (bitn < 8) begin
        t = {sh[6:0], sda_line}; sh = t; bitn = bitn + 1;
        if (bitn == 8) cap.push_back(t);
      end else begin
        bitn = 0; byte_no = byte_no + 1;
      end
    end
    if (!scl_line && prev_scl) slave_pull = (bitn == 8) && (byte_no != nack_byte);
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  logic [7:0] tx_data [0:7];
  int done_cnt, wr_seen, cap_base, start_base, stop_base;
  logic nack_seen;

  function automatic logic [15:0] pack(input int k, input int n);
    logic [7:0] lo, hi;
    lo = (2*k < n)     ? tx_data[2*k]     : 8'hEE;
    hi = (2*k + 1 < n) ? tx_data[2*k + 1] : 8'hEE;
    return {hi, lo};
  endfunction

  task automatic run_xfer(input logic [6:0] addr, input int n, input int nack_at,
                          input int late, input bit poke);
    int acc, first_acc, post, nbuf;
    bit rdy_prev;
    nbuf = (n + 1) / 2; acc = 0; first_acc = 0; post = 0; rdy_prev = 0;
    done_cnt = 0; wr_seen = 0; nack_seen = 1'b0; nack_byte = nack_at;
    cap_base = cap.size(); start_base = starts; stop_base = stops;
    @(negedge clk); SlaveAddr = addr; NumBytes = 16'(n); StartTX = 1'b1;
    @(negedge clk); StartTX = 1'b0;
    for (int cyc = 0; cyc < 5000 && post < 20; cyc++) begin
      if (WrValid && rdy_prev) begin
        acc++;
        if (acc == 1) first_acc = cyc;
      end
      rdy_prev = WrReady;
      if (WrReady) wr_seen = 1;
      if (Done) begin done_cnt++; nack_seen = NackErr; end
      if (done_cnt > 0) post++;
      StartTX = poke && (cyc == 30);
      if (poke && cyc == 30) SlaveAddr = 7'h7F;
      if (acc < nbuf && (acc == 0 || cyc >= first_acc + late)) begin
        WrValid = 1'b1; WrData = pack(acc, n);
      end else begin
        WrValid = 1'b0;
      end
      @(negedge clk);
    end
    WrValid = 1'b0; StartTX = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (SDA_oe !== 1'b0)  begin errors++; $display("FAIL rst_sda_oe got %b exp 0", SDA_oe); end
    checks++; if (SCL_oe !== 1'b0)  begin errors++; $display("FAIL rst_scl_oe got %b exp 0", SCL_oe); end
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b exp 0", Done); end
    checks++; if (NackErr !== 1'b0) begin errors++; $display("FAIL rst_nackerr got %b exp 0", NackErr); end
    checks++; if (WrReady !== 1'b0) begin errors++; $display("FAIL rst_wrready got %b exp 0", WrReady); end
  endtask

  task automatic test_basic;
    logic [7:0] e [0:3];
    logic [7:0] got;
    e[0] = 8'hA0; e[1] = 8'hA1; e[2] = 8'hB2; e[3] = 8'hC3;
    tx_data[0] = 8'hA1; tx_data[1] = 8'hB2; tx_data[2] = 8'hC3;
    run_xfer(7'h50, 3, -1, 0, 1'b1);
    checks++; if (cap.size() - cap_base !== 4) begin errors++; $display("FAIL basic_len got %0d exp 4", cap.size() - cap_base); end
    for (int i = 0; i < 4; i++) begin
      got = 8'hxx;
      if (cap_base + i < cap.size()) got = cap[cap_base + i];
      checks++; if (got !== e[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got, e[i]); end
    end
    checks++; if (done_cnt !== 1)      begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt); end
    checks++; if (nack_seen !== 1'b0)  begin errors++; $display("FAIL basic_nack got %b exp 0", nack_seen); end
    checks++; if (min_per !== 8)       begin errors++; $display("FAIL basic_scl_min got %0d exp 8", min_per); end
    checks++; if (max_per !== 8)       begin errors++; $display("FAIL basic_scl_max got %0d exp 8", max_per); end
    checks++; if (starts - start_base !== 1) begin errors++; $display("FAIL basic_starts got %0d exp 1", starts - start_base); end
    checks++; if (stops - stop_base !== 1)   begin errors++; $display("FAIL basic_stops got %0d exp 1", stops - stop_base); end
  endtask

  task automatic test_zero_len;
    logic [7:0] got;
    run_xfer(7'h3C, 0, -1, 0, 1'b0);
    got = 8'hxx;
    if (cap_base < cap.size()) got = cap[cap_base];
    checks++; if (cap.size() - cap_base !== 1) begin errors++; $display("FAIL zero_len got %0d exp 1", cap.size() - cap_base); end
    checks++; if (got !== 8'h78)      begin errors++; $display("FAIL zero_addr got %h exp 78", got); end
    checks++; if (wr_seen !== 0)      begin errors++; $display("FAIL zero_wrready got %0d exp 0", wr_seen); end
    checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL zero_done got %0d exp 1", done_cnt); end
    checks++; if (nack_seen !== 1'b0) begin errors++; $display("FAIL zero_nack got %b exp 0", nack_seen); end
    checks++; if (stops - stop_base !== 1) begin errors++; $display("FAIL zero_stops got %0d exp 1", stops - stop_base); end
  endtask

  task automatic test_addr_nack;
    logic [7:0] got;
    tx_data[0] = 8'h11; tx_data[1] = 8'h22;
    run_xfer(7'h2A, 2, 0, 0, 1'b0);
    got = 8'hxx;
    if (cap_base < cap.size()) got = cap[cap_base];
    checks++; if (cap.size() - cap_base !== 1) begin errors++; $display("FAIL anack_len got %0d exp 1", cap.size() - cap_base); end
    checks++; if (got !== 8'h54)      begin errors++; $display("FAIL anack_addr got %h exp 54", got); end
    checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL anack_done got %0d exp 1", done_cnt); end
    checks++; if (nack_seen !== 1'b1) begin errors++; $display("FAIL anack_nack got %b exp 1", nack_seen); end
    checks++; if (stops - stop_base !== 1) begin errors++; $display("FAIL anack_stops got %0d exp 1", stops - stop_base); end
  endtask

  task automatic test_underrun;
    logic [7:0] e [0:5];
    logic [7:0] got;
    e[0] = 8'h1E; e[1] = 8'h11; e[2] = 8'h22; e[3] = 8'h33; e[4] = 8'h44; e[5] = 8'h55;
    for (int i = 0; i < 5; i++) tx_data[i] = e[i+1];
    run_xfer(7'h0F, 5, -1, 280, 1'b0);
    checks++; if (cap.size() - cap_base !== 6) begin errors++; $display("FAIL under_len got %0d exp 6", cap.size() - cap_base); end
    for (int i = 0; i < 6; i++) begin
      got = 8'hxx;
      if (cap_base + i < cap.size()) got = cap[cap_base + i];
      checks++; if (got !== e[i]) begin errors++; $display("FAIL under_byte%0d got %h exp %h", i, got, e[i]); end
    end
    checks++; if (max_per < 40)       begin errors++; $display("FAIL under_stretch got %0d exp >=40", max_per); end
    checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL under_done got %0d exp 1", done_cnt); end
    checks++; if (nack_seen !== 1'b0) begin errors++; $display("FAIL under_nack got %b exp 0", nack_seen); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got;
    tx_data[0] = 8'hD0; tx_data[1] = 8'hD1; tx_data[2] = 8'hD2; tx_data[3] = 8'hD3;
    run_xfer(7'h33, 4, 2, 0, 1'b0);
    checks++; if (cap.size() - cap_base !== 3) begin errors++; $display("FAIL dnack_len got %0d exp 3", cap.size() - cap_base); end
    checks++; if (nack_seen !== 1'b1) begin errors++; $display("FAIL dnack_nack got %b exp 1", nack_seen); end
    checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL dnack_done got %0d exp 1", done_cnt); end
    checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL dnack_busy got %b exp 0", Busy); end
    checks++; if (WrReady !== 1'b0)   begin errors++; $display("FAIL dnack_wrready got %b exp 0", WrReady); end
    tx_data[0] = 8'h5A;
    run_xfer(7'h11, 1, -1, 0, 1'b0);
    checks++; if (cap.size() - cap_base !== 2) begin errors++; $display("FAIL b2b_len got %0d exp 2", cap.size() - cap_base); end
    got = 8'hxx;
    if (cap_base + 1 < cap.size()) got = cap[cap_base + 1];
    checks++; if (got !== 8'h5A)      begin errors++; $display("FAIL b2b_data got %h exp 5a", got); end
    checks++; if (nack_seen !== 1'b0) begin errors++; $display("FAIL b2b_nack got %b exp 0", nack_seen); end
  endtask

  task automatic test_reset_mid;
    int base, waited;
    base = cap.size(); waited = 0; nack_byte = -1;
    tx_data[0] = 8'h96; tx_data[1] = 8'h69;
    @(negedge clk); SlaveAddr = 7'h44; NumBytes = 16'd2; StartTX = 1'b1;
    WrData = pack(0, 2); WrValid = 1'b1;
    @(negedge clk); StartTX = 1'b0;
    @(negedge clk); WrValid = 1'b0;
    while (cap.size() == base && waited < 1000) begin @(negedge clk); waited++; end
    checks++; if (waited >= 1000) begin errors++; $display("FAIL rstmid_timeout got %0d exp <1000", waited); end
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (SDA_oe !== 1'b0)  begin errors++; $display("FAIL rstmid_sda got %b exp 0", SDA_oe); end
    checks++; if (SCL_oe !== 1'b0)  begin errors++; $display("FAIL rstmid_scl got %b exp 0", SCL_oe); end
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b exp 0", Busy); end
    checks++; if (WrReady !== 1'b0) begin errors++; $display("FAIL rstmid_wrready got %b exp 0", WrReady); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL rstmid_idle got %b exp 0", Busy); end
  endtask

  initial begin
    test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic;
    test_zero_len;
    test_addr_nack;
    test_underrun;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
